id_stage_pipe: RTL

- Registered RV32I decode stage with a valid/ready handshake in front of EX.
- Replaces the purely combinational decoder. Adds a configurable data width and two-level forwarding (EX, then MEM).
- Adds load-use hazard stall, flush, load/store size decode and a sticky illegal-instruction flag.
- Sits between the IF/ID register and EX. Register-file reads stay asynchronous.

---
 rtl/id_stage_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - registered RV32I decode stage with forwarding, load-use stall and flush
module id_stage_pipe #(
  parameter int XLEN        = 32,
  parameter int MEM_FWD     = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            instr_i,
  input  logic [XLEN-1:0]        pc_i,
  output logic [4:0]             gprs_raddr1,
  output logic [4:0]             gprs_raddr2,
  input  logic [XLEN-1:0]        gprs_rdata1_i,
  input  logic [XLEN-1:0]        gprs_rdata2_i,
  input  logic [4:0]             ex_gprs_waddr,
  input  logic [XLEN-1:0]        ex_gprs_wdata,
  input  logic                   ex_is_load,
  input  logic [4:0]             mem_gprs_waddr,
  input  logic [XLEN-1:0]        mem_gprs_wdata,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             rtlop_o,
  output logic [1:0]             rtltype_o,
  output logic [2:0]             memsize_o,
  output logic [XLEN-1:0]        pc_o,
  output logic [XLEN-1:0]        src1_o,
  output logic [XLEN-1:0]        src2_o,
  output logic [XLEN-1:0]        sdata_o,
  output logic [4:0]             gprs_waddr_o,
  output logic                   error_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [6:0] OP_I = 7'h13, OP_R = 7'h33, OP_L = 7'h03, OP_S = 7'h23;
  localparam logic [6:0] OP_JAL = 7'h6f, OP_JALR = 7'h67, OP_B = 7'h63;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17;
  localparam logic [1:0] T_ARICH = 2'd0, T_RMEM = 2'd1, T_WMEM = 2'd2, T_JUMP = 2'd3;
  localparam logic [3:0] ALU_ADD = 4'h0, ALU_SAR = 4'hd;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rs1, rs2, rd;
  logic [XLEN-1:0] i_imm, s_imm, b_imm, j_imm, u_imm;

  assign opcode = instr_i[6:0];
  assign rd     = instr_i[11:7];
  assign funct3 = instr_i[14:12];
  assign rs1    = instr_i[19:15];
  assign rs2    = instr_i[24:20];
  assign funct7 = instr_i[31:25];
  assign gprs_raddr1 = rs1;
  assign gprs_raddr2 = rs2;

  assign i_imm = XLEN'($signed(instr_i[31:20]));
  assign s_imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
  assign b_imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
  assign j_imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
  assign u_imm = XLEN'($signed({instr_i[31:12], 12'b0}));

  // x0 wins over any forwarding source; EX is younger than MEM so it takes priority
  logic [XLEN-1:0] op1, op2;
  always_comb begin
    op1 = gprs_rdata1_i;
    if (rs1 == 5'd0)                                   op1 = '0;
    else if (ex_gprs_waddr == rs1)                     op1 = ex_gprs_wdata;
    else if ((MEM_FWD != 0) && (mem_gprs_waddr == rs1)) op1 = mem_gprs_wdata;
    op2 = gprs_rdata2_i;
    if (rs2 == 5'd0)                                   op2 = '0;
    else if (ex_gprs_waddr == rs2)                     op2 = ex_gprs_wdata;
    else if ((MEM_FWD != 0) && (mem_gprs_waddr == rs2)) op2 = mem_gprs_wdata;
  end

  logic [3:0]      d_op;
  logic [1:0]      d_type;
  logic [2:0]      d_size;
  logic [XLEN-1:0] d_src1, d_src2, d_sdata;
  logic [4:0]      d_waddr;
  logic            d_illegal, use1, use2, taken;

  always_comb begin
    d_op = ALU_ADD; d_type = T_ARICH; d_size = 3'd0;
    d_src1 = '0; d_src2 = '0; d_sdata = '0; d_waddr = 5'd0;
    d_illegal = 1'b0; use1 = 1'b0; use2 = 1'b0; taken = 1'b0;
    case (opcode)
      OP_I: begin
        use1 = 1'b1; d_src1 = op1; d_src2 = i_imm; d_op = {1'b0, funct3}; d_waddr = rd;
        if (funct3 == 3'd1 && funct7 != 7'h00) d_illegal = 1'b1;
        if (funct3 == 3'd5) begin
          if (funct7 == 7'h20)      d_op = ALU_SAR;
          else if (funct7 != 7'h00) d_illegal = 1'b1;
        end
      end
      OP_R: begin
        use1 = 1'b1; use2 = 1'b1; d_src1 = op1; d_src2 = op2; d_op = {1'b0, funct3}; d_waddr = rd;
        if (funct7 == 7'h20) begin
          if (funct3 == 3'd0)      d_src2 = -op2;
          else if (funct3 == 3'd5) d_op = ALU_SAR;
          else                     d_illegal = 1'b1;
        end else if (funct7 != 7'h00) d_illegal = 1'b1;
      end
      OP_L: begin
        use1 = 1'b1; d_type = T_RMEM; d_src1 = op1; d_src2 = i_imm; d_size = funct3; d_waddr = rd;
        if (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7) d_illegal = 1'b1;
      end
      OP_S: begin
        use1 = 1'b1; use2 = 1'b1; d_type = T_WMEM; d_src1 = op1 + s_imm; d_sdata = op2; d_size = funct3;
        if (funct3 > 3'd2) d_illegal = 1'b1;
      end
      OP_JAL:  begin d_type = T_JUMP; d_src1 = pc_i; d_src2 = j_imm; d_waddr = rd; end
      OP_JALR: begin use1 = 1'b1; d_type = T_JUMP; d_src1 = op1; d_src2 = i_imm; d_waddr = rd; end
      OP_B: begin
        use1 = 1'b1; use2 = 1'b1; d_src1 = pc_i; d_src2 = b_imm;
        case (funct3)
          3'd0: taken = (op1 == op2);
          3'd1: taken = (op1 != op2);
          3'd4: taken = ($signed(op1) <  $signed(op2));
          3'd5: taken = ($signed(op1) >= $signed(op2));
          3'd6: taken = (op1 <  op2);
          3'd7: taken = (op1 >= op2);
          default: d_illegal = 1'b1;
        endcase
        d_type = taken ? T_JUMP : T_ARICH;
      end
      OP_LUI:   begin d_src1 = u_imm; d_waddr = rd; end
      OP_AUIPC: begin d_src1 = pc_i; d_src2 = u_imm; d_waddr = rd; end
      default:  d_illegal = 1'b1;
    endcase
  end

  logic hazard, accept;
  assign hazard = in_valid & ex_is_load & (ex_gprs_waddr != 5'd0) &
                  ((use1 & (ex_gprs_waddr == rs1)) | (use2 & (ex_gprs_waddr == rs2)));
  assign in_ready = !rst & !flush & !hazard & (!out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0; rtlop_o <= '0; rtltype_o <= '0; memsize_o <= '0; pc_o <= '0;
      src1_o <= '0; src2_o <= '0; sdata_o <= '0; gprs_waddr_o <= '0;
      error_o <= 1'b0; stall_cnt_o <= '0;
    end else begin
      if (hazard && !flush && stall_cnt_o != {STALL_CNT_W{1'b1}})
        stall_cnt_o <= stall_cnt_o + STALL_CNT_W'(1);
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        pc_o      <= pc_i;
        if (d_illegal) begin
          // illegal instructions retire as a harmless ADD with no writeback
          rtlop_o <= ALU_ADD; rtltype_o <= T_ARICH; memsize_o <= '0;
          src1_o <= '0; src2_o <= '0; sdata_o <= '0; gprs_waddr_o <= '0;
          error_o <= 1'b1;
        end else begin
          rtlop_o <= d_op; rtltype_o <= d_type; memsize_o <= d_size;
          src1_o <= d_src1; src2_o <= d_src2; sdata_o <= d_sdata; gprs_waddr_o <= d_waddr;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
